// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two MIPS requesters, the arbiter and the single RAM port.
// The arbiter takes the slave view; the requester/RAM environment takes the master view.
interface ram_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one RAM port between instruction fetch and data memory. Registered grant,
// data priority with a starvation bound for fetch, plus error count and sticky timeout.
module ram_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  ram_arbiter_if.slave     bus,
  output logic [7:0]       err_cnt,
  output logic             timeout
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BusyW   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [1:0] {StIdle, StIgnt, StDgnt} state_e;

  state_e               state_q, state_d;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic [BusyW-1:0]     busy_q, busy_d;
  logic [7:0]           err_q, err_d;
  logic                 timeout_q, timeout_d;

  logic dreq, access, granted, starve_max, busy_hit;

  assign dreq       = bus.dREN | bus.dWEN;
  assign access     = (bus.ramstate == RamAccess);
  assign granted    = (state_q != StIdle);
  assign starve_max = (starve_q == StarveW'(STARVE_MAX));
  // Asserted during the TIMEOUT-th stalled cycle of a grant so the flag shows in that cycle.
  assign busy_hit   = granted && !access && (busy_q == BusyW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dreq && !(bus.iREN && starve_max)) begin
          state_d = StDgnt;
        end else if (bus.iREN) begin
          state_d = StIgnt;
        end
      end
      StIgnt: if (access || !bus.iREN) state_d = StIdle;
      StDgnt: if (access || !dreq)     state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; enables follow the live request so a withdrawal drops them at once.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    unique case (state_q)
      StIgnt: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (access) bus.iload = bus.ramload;
      end
      StDgnt: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (access) bus.dload = bus.ramload;
      end
      default: ;
    endcase
    bus.iwait = bus.iREN & ~((state_q == StIgnt) & access);
    bus.dwait = dreq & ~((state_q == StDgnt) & access);
  end

  // Starvation, busy, error and timeout bookkeeping
  always_comb begin
    starve_d = starve_q;
    if (state_q == StIgnt && state_d == StIdle) begin
      starve_d = '0;
    end else if (state_q == StDgnt && state_d == StIdle) begin
      if (!bus.iREN)       starve_d = '0;
      else if (!starve_max) starve_d = starve_q + 1'b1;
    end

    busy_d = busy_q;
    if (!granted || state_d == StIdle) begin
      busy_d = '0;
    end else if (!access && busy_q != BusyW'(TIMEOUT)) begin
      busy_d = busy_q + 1'b1;
    end

    err_d = err_q;
    if (granted && bus.ramstate == RamError && err_q != 8'hff) begin
      err_d = err_q + 8'd1;
    end

    timeout_d = timeout_q | busy_hit;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q  <= '0;
      busy_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign err_cnt = err_q;
  assign timeout = timeout_q | busy_hit;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: fetch, write, starvation bound, error retry,
// timeout with async reset, and request withdrawal.
module tb_ram_arbiter;

  localparam logic [1:0] Free   = 2'd0;
  localparam logic [1:0] Busy   = 2'd1;
  localparam logic [1:0] Access = 2'd2;
  localparam logic [1:0] Error  = 2'd3;

  logic       CLK;
  logic       nRST;
  logic [7:0] err_cnt;
  logic       timeout;
  int         checks;
  int         failures;

  ram_arbiter_if bus ();

  ram_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT   (64)
  ) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus    (bus),
    .err_cnt(err_cnt),
    .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = Free;
  endtask

  task automatic test_reset();
    idle_all();
    bus.iREN = 1'b1;
    bus.dREN = 1'b1;
    #3;
    checks++; if (bus.iwait !== 1'b1) begin failures++; $display("FAIL reset_iwait: got %0h want 1", bus.iwait); end
    checks++; if (bus.dwait !== 1'b1) begin failures++; $display("FAIL reset_dwait: got %0h want 1", bus.dwait); end
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin failures++; $display("FAIL reset_ram_en: got %0h want 0", {bus.ramREN, bus.ramWEN}); end
    checks++; if (bus.ramaddr !== 32'h0) begin failures++; $display("FAIL reset_ramaddr: got %0h want 0", bus.ramaddr); end
    checks++; if (err_cnt !== 8'h0) begin failures++; $display("FAIL reset_err_cnt: got %0h want 0", err_cnt); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %0h want 0", timeout); end
    idle_all();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_ifetch();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    #1;
    checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL ifetch_c1_ramren: got %0h want 0", bus.ramREN); end
    tick();
    bus.ramstate = Access;
    bus.ramload  = 32'hDEADBEEF;
    #1;
    checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL ifetch_c2_ramren: got %0h want 1", bus.ramREN); end
    checks++; if (bus.ramaddr !== 32'h40) begin failures++; $display("FAIL ifetch_c2_ramaddr: got %0h want 40", bus.ramaddr); end
    checks++; if (bus.iload !== 32'hDEADBEEF) begin failures++; $display("FAIL ifetch_c2_iload: got %0h want deadbeef", bus.iload); end
    checks++; if (bus.iwait !== 1'b0) begin failures++; $display("FAIL ifetch_c2_iwait: got %0h want 0", bus.iwait); end
    tick();
    bus.ramstate = Free;
    #1;
    // Still requesting, but back in IDLE: nothing on the RAM port and still waited.
    checks++; if (bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h0) begin failures++; $display("FAIL ifetch_c3_idle: got ren=%0h addr=%0h want 0/0", bus.ramREN, bus.ramaddr); end
    checks++; if (bus.iwait !== 1'b1) begin failures++; $display("FAIL ifetch_c3_iwait: got %0h want 1", bus.iwait); end
    idle_all();
    tick();
  endtask

  task automatic test_write();
    bus.dWEN   = 1'b1;
    bus.dREN   = 1'b1;
    bus.daddr  = 32'h80;
    bus.dstore = 32'h1234;
    #1;
    checks++; if (bus.dwait !== 1'b1 || bus.ramWEN !== 1'b0) begin failures++; $display("FAIL write_c1: got dwait=%0h wen=%0h want 1/0", bus.dwait, bus.ramWEN); end
    tick();
    bus.ramstate = Busy;
    #1;
    checks++; if ({bus.ramWEN, bus.ramREN} !== 2'b10) begin failures++; $display("FAIL write_en: got wen,ren=%0b want 10", {bus.ramWEN, bus.ramREN}); end
    checks++; if (bus.ramstore !== 32'h1234) begin failures++; $display("FAIL write_ramstore: got %0h want 1234", bus.ramstore); end
    checks++; if (bus.ramaddr !== 32'h80) begin failures++; $display("FAIL write_ramaddr: got %0h want 80", bus.ramaddr); end
    checks++; if (bus.dwait !== 1'b1) begin failures++; $display("FAIL write_busy_dwait: got %0h want 1", bus.dwait); end
    tick();
    bus.ramstate = Access;
    #1;
    checks++; if (bus.dwait !== 1'b0) begin failures++; $display("FAIL write_access_dwait: got %0h want 0", bus.dwait); end
    idle_all();
    tick();
  endtask

  task automatic test_starve();
    // 0 = idle, 1 = data grant, 2 = instruction grant
    int exp_code [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1};
    int code;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h200;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h100;
    bus.ramstate = Access;
    bus.ramload  = 32'h5A5A0001;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      #1;
      if (!bus.ramREN)                code = 0;
      else if (bus.ramaddr == 32'h100) code = 1;
      else if (bus.ramaddr == 32'h200) code = 2;
      else                            code = 3;
      checks++;
      if (code !== exp_code[i]) begin
        failures++;
        $display("FAIL starve_seq[%0d]: got grant %0d want %0d", i, code, exp_code[i]);
      end
      if (i == 1) begin
        checks++; if (bus.dload !== 32'h5A5A0001) begin failures++; $display("FAIL starve_dload: got %0h want 5a5a0001", bus.dload); end
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_error();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h300;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.ramstate = Error;
      #1;
      checks++; if (bus.dwait !== 1'b1) begin failures++; $display("FAIL error_dwait[%0d]: got %0h want 1", i, bus.dwait); end
      tick();
    end
    bus.ramstate = Access;
    bus.ramload  = 32'hCAFE;
    #1;
    checks++; if (bus.dwait !== 1'b0) begin failures++; $display("FAIL error_access_dwait: got %0h want 0", bus.dwait); end
    checks++; if (bus.dload !== 32'hCAFE) begin failures++; $display("FAIL error_dload: got %0h want cafe", bus.dload); end
    checks++; if (err_cnt !== 8'd3) begin failures++; $display("FAIL error_err_cnt: got %0d want 3", err_cnt); end
    idle_all();
    tick();
  endtask

  task automatic test_timeout();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h44;
    for (int k = 1; k <= 64; k++) begin
      tick();
      bus.ramstate = Busy;
      #1;
      if (k == 63) begin
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_c63: got %0h want 0", timeout); end
      end
      if (k == 64) begin
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_c64: got %0h want 1", timeout); end
      end
    end
    tick();
    bus.ramstate = Access;
    #1;
    checks++; if (bus.iwait !== 1'b0) begin failures++; $display("FAIL timeout_complete_iwait: got %0h want 0", bus.iwait); end
    tick();
    idle_all();
    #1;
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %0h want 1", timeout); end

    // Async reset in the middle of a grant
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h60;
    tick();
    bus.ramstate = Busy;
    #1;
    checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL rst_pre_ramren: got %0h want 1", bus.ramREN); end
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h0) begin failures++; $display("FAIL rst_async_ram: got ren=%0h addr=%0h want 0/0", bus.ramREN, bus.ramaddr); end
    checks++; if (timeout !== 1'b0 || err_cnt !== 8'h0) begin failures++; $display("FAIL rst_async_flags: got to=%0h err=%0h want 0/0", timeout, err_cnt); end
    checks++; if (bus.iwait !== 1'b1) begin failures++; $display("FAIL rst_async_iwait: got %0h want 1", bus.iwait); end
    idle_all();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_withdraw();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h48;
    tick();
    bus.ramstate = Busy;
    #1;
    checks++; if (bus.ramREN !== 1'b1) begin failures++; $display("FAIL withdraw_granted: got %0h want 1", bus.ramREN); end
    bus.iREN = 1'b0;
    #1;
    checks++; if (bus.ramREN !== 1'b0) begin failures++; $display("FAIL withdraw_same_cycle: got %0h want 0", bus.ramREN); end
    tick();
    bus.ramstate = Free;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h500;
    #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin failures++; $display("FAIL withdraw_idle: got ren=%0h dwait=%0h want 0/1", bus.ramREN, bus.dwait); end
    tick();
    bus.ramstate = Access;
    #1;
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h500) begin failures++; $display("FAIL withdraw_dgrant: got ren=%0h addr=%0h want 1/500", bus.ramREN, bus.ramaddr); end
    checks++; if (bus.dwait !== 1'b0) begin failures++; $display("FAIL withdraw_dwait: got %0h want 0", bus.dwait); end
    idle_all();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST     = 1'b0;
    test_reset();
    test_ifetch();
    test_write();
    test_starve();
    test_error();
    test_timeout();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined MIPS core.
- Registered grant FSM: data requests take priority; a starvation counter guarantees instruction-fetch progress.
- Returns per-requester wait/load, and tracks RAM-port error and timeout events.

Parameters:
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before instruction fetch is forced next.
- TIMEOUT, 64, cycles a granted transaction may stay non-ACCESS before the timeout flag is raised.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iwait  out  1  instruction request not yet complete
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write data
- dwait  out  1  data request not yet complete
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err_cnt  out  8  saturating count of ERROR responses
- timeout  out  1  sticky flag; set when any transaction exceeds TIMEOUT

Behaviour:
- States: IDLE, IGNT, DGNT.
- Reset (nRST low, async): state=IDLE, starve counter=0, busy counter=0, err_cnt=0, timeout=0.
- RAM outputs under reset: ramREN=ramWEN=0, ramaddr=ramstore=0.
- Wait outputs are combinational:
  - iwait = iREN & ~(state==IGNT & ramstate==ACCESS)
  - dwait = (dREN|dWEN) & ~(state==DGNT & ramstate==ACCESS)
- Under reset: iwait=iREN, dwait=dREN|dWEN.
- Grant decision is registered: a request seen in IDLE reaches the RAM one cycle later, so minimum latency is 2 cycles (request to ACCESS completion) when the RAM answers on its first granted cycle.
- IDLE transitions:
  - dREq (dREN|dWEN) & ~(iREN & starve==STARVE_MAX) -> DGNT
  - else iREN -> IGNT
  - else stay IDLE.
- IGNT:
  - Drives ramREN=iREN, ramaddr=iaddr, ramWEN=0.
  - iload=ramload when ramstate==ACCESS; iload=0 otherwise.
  - On ACCESS or iREN low: go to IDLE and clear the starve counter.
- DGNT:
  - Drives ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both are asserted).
  - dload=ramload when ramstate==ACCESS; dload=0 otherwise.
  - On ACCESS or dREq low: go to IDLE.
  - On exit, increment the starve counter if iREN is high (saturate at STARVE_MAX); else clear it.
- RAM outputs are 0 in IDLE. Enables always gate combinationally with the current request, so a request withdrawn mid-grant drops the RAM enable in the same cycle.
- ERROR:
  - err_cnt increments, saturating at 255.
  - The FSM holds the grant; the requester stays waited and the access retries until ACCESS or the request is withdrawn.
- Busy counter:
  - Counts granted cycles with ramstate!=ACCESS; cleared on leaving a grant state.
  - Reaching TIMEOUT sets the timeout flag (sticky until reset). The grant is not aborted.
- Back-to-back requests: every completion returns through IDLE for one cycle. There is no grant chaining.
- Simultaneous iREN and dREq in IDLE with starve<STARVE_MAX: data wins.

Test Plan:
- iREN=1, iaddr=0x40, ramstate=ACCESS on the first granted cycle, ramload=0xDEADBEEF:
  - ramREN=1 with ramaddr=0x40 in cycle 2
  - iload=0xDEADBEEF and iwait=0 in cycle 2
  - state IDLE in cycle 3.
- dWEN=1, dREN=1, daddr=0x80, dstore=0x1234:
  - ramWEN=1, ramREN=0, ramstore=0x1234
  - dwait deasserts on ACCESS.
- iREN held high, dREN re-asserted every idle cycle, STARVE_MAX=4:
  - exactly 4 data grants
  - then an instruction grant
  - starve counter resets to 0.
- Granted dREN, ramstate=ERROR for 3 cycles then ACCESS:
  - err_cnt=3
  - dwait=1 for those 3 cycles, 0 on ACCESS.
- Granted iREN with ramstate=BUSY for 64 cycles:
  - timeout=1 on cycle 64 of the grant and stays 1 after completion.
  - nRST low mid-grant: outputs return to reset values asynchronously.
- iREN dropped mid-grant (BUSY):
  - ramREN=0 in the same cycle
  - state IDLE next cycle
  - a subsequent dREN is granted normally.
